// File: rtl/uart_matrix_cfg_pkg.sv
// uart_matrix_cfg_pkg: framing bytes and FSM encodings for the matrix config sequencer
package uart_matrix_cfg_pkg;
  localparam logic [7:0] HDR = 8'hA5;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;
  localparam logic [2:0] S_INIT = 3'd0;
  localparam logic [2:0] S_IDLE = 3'd1;
  localparam logic [2:0] S_ROW  = 3'd2;
  localparam logic [2:0] S_MASK = 3'd3;
  localparam logic [2:0] S_CHK  = 3'd4;
endpackage

// File: rtl/uart_matrix_cfg.sv
// uart_matrix_cfg: loads a default routing map, then writes LUT rows from framed UART commands
module uart_matrix_cfg
  import uart_matrix_cfg_pkg::*;
#(
  parameter int m       = 8,
  parameter int n       = 8,
  parameter int TIMEOUT = 100000,
  parameter int SELF    = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   rx_data,
  input  logic         rx_stb,
  output logic [m-1:0] lut_addr,
  output logic [n-1:0] lut_data,
  output logic         lut_cke,
  output logic [7:0]   ack_data,
  output logic         ack_stb,
  output logic         busy,
  output logic [7:0]   err_cnt
);
  localparam int NB = (n + 7) / 8;
  localparam int MW = NB * 8;
  localparam int RW = $clog2(m) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [2:0]    st_q, st_d;
  logic [RW-1:0] r_q, r_d;
  logic [7:0]    row_q, row_d, chk_q, chk_d, b_q, b_d, err_q, err_d, ack_data_q, ack_data_d;
  logic [MW-1:0] mask_q, mask_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [m-1:0]  addr_q, addr_d;
  logic [n-1:0]  data_q, data_d;
  logic          cke_q, cke_d, ack_q, ack_d, busy_q, in_frame, expire, bump;
  // Next state: INIT sweep, frame parsing, response and inter-byte timeout
  always_comb begin
    in_frame   = st_q == S_ROW || st_q == S_MASK || st_q == S_CHK;
    expire     = in_frame && !rx_stb && tmo_q == TW'(TIMEOUT);
    st_d       = st_q;
    r_d        = r_q;
    row_d      = row_q;
    chk_d      = chk_q;
    b_d        = b_q;
    mask_d     = mask_q;
    addr_d     = addr_q;
    data_d     = data_q;
    cke_d      = 1'b0;
    ack_d      = 1'b0;
    ack_data_d = ack_data_q;
    bump       = 1'b0;
    tmo_d      = (rx_stb || !in_frame || expire) ? '0 : tmo_q + 1'b1;
    case (st_q)
      S_INIT: begin
        cke_d  = 1'b1;
        addr_d = m'(r_q);
        data_d = SELF != 0 ? '1 : ~(n'(1) << r_q);
        r_d    = r_q + 1'b1;
        st_d   = r_q == RW'(m - 1) ? S_IDLE : S_INIT;
      end
      S_IDLE: st_d = (rx_stb && rx_data == HDR) ? S_ROW : S_IDLE;
      S_ROW: if (rx_stb) begin
        row_d = rx_data;
        chk_d = rx_data;
        b_d   = '0;
        st_d  = S_MASK;
      end
      S_MASK: if (rx_stb) begin
        mask_d = (mask_q >> 8) | (MW'(rx_data) << (MW - 8));
        chk_d  = chk_q ^ rx_data;
        b_d    = b_q + 1'b1;
        st_d   = b_q == 8'(NB - 1) ? S_CHK : S_MASK;
      end
      S_CHK: if (rx_stb) begin
        ack_d = 1'b1;
        st_d  = S_IDLE;
        if (rx_data == chk_q && row_q < 8'(m)) begin
          cke_d      = 1'b1;
          addr_d     = m'(row_q);
          data_d     = mask_q[n-1:0];
          ack_data_d = ACK;
        end else begin
          ack_data_d = NAK;
          bump       = 1'b1;
        end
      end
      default: st_d = S_IDLE;
    endcase
    if (expire) begin
      st_d = S_IDLE;
      bump = 1'b1;
    end
    err_d = err_q + 8'(bump && err_q != 8'hFF);
  end
  // State and registered outputs; reset restarts the default-map sweep
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      st_q       <= S_INIT;
      r_q        <= '0;
      row_q      <= '0;
      chk_q      <= '0;
      b_q        <= '0;
      mask_q     <= '0;
      tmo_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      cke_q      <= 1'b0;
      ack_q      <= 1'b0;
      ack_data_q <= '0;
      err_q      <= '0;
      busy_q     <= 1'b1;
    end else begin
      st_q       <= st_d;
      r_q        <= r_d;
      row_q      <= row_d;
      chk_q      <= chk_d;
      b_q        <= b_d;
      mask_q     <= mask_d;
      tmo_q      <= tmo_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      cke_q      <= cke_d;
      ack_q      <= ack_d;
      ack_data_q <= ack_data_d;
      err_q      <= err_d;
      busy_q     <= st_q == S_INIT;
    end
  assign lut_addr = addr_q;
  assign lut_data = data_q;
  assign lut_cke  = cke_q;
  assign ack_data = ack_data_q;
  assign ack_stb  = ack_q;
  assign busy     = busy_q;
  assign err_cnt  = err_q;
endmodule

// File: tb/tb_uart_matrix_cfg.sv
// tb_uart_matrix_cfg: randomized and directed checks of the matrix config sequencer
module tb_uart_matrix_cfg;
  logic       clk = 1'b0, reset = 1'b1, rx_stb = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [7:0] lut_addr, lut_data, ack_data, err_cnt;
  logic       lut_cke, ack_stb, busy;
  int vectors = 0, miscompares = 0, err_m = 0, dbl = 0, acks = 0, wrs = 0;
  logic prev_cke = 1'b0, prev_ack = 1'b0;

  always #5 clk = ~clk;

  uart_matrix_cfg #(.m(8), .n(8), .TIMEOUT(50), .SELF(0)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_stb(rx_stb),
    .lut_addr(lut_addr), .lut_data(lut_data), .lut_cke(lut_cke),
    .ack_data(ack_data), .ack_stb(ack_stb), .busy(busy), .err_cnt(err_cnt)
  );

  // pulse monitor: counts strobes and flags any strobe held two cycles outside INIT
  always @(negedge clk) begin
    if ((lut_cke && prev_cke && !busy) || (ack_stb && prev_ack)) dbl++;
    if (lut_cke) wrs++;
    if (ack_stb) acks++;
    prev_cke = lut_cke;
    prev_ack = ack_stb;
  end

  function automatic logic [17:0] resp();
    return {lut_cke, ack_stb, ack_data, err_cnt};
  endfunction

  function automatic logic [15:0] wr();
    return {lut_addr, lut_data};
  endfunction

  function automatic int sat(input int e);
    return e >= 255 ? 255 : e + 1;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_stb  = 1'b1;
    @(negedge clk);
    rx_stb  = 1'b0;
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 4)) @(negedge clk);
  endtask

  task automatic check_init(input string tag);
    logic [7:0] exp_d;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp_d = 8'hFF & ~(8'd1 << i);
      vectors++;
      if ({lut_cke, busy, lut_addr, lut_data} !== {2'b11, 8'(i), exp_d}) begin
        miscompares++;
        $display("FAIL %s_row%0d got cke=%b busy=%b addr=%h data=%h want 1 1 %h %h",
                 tag, i, lut_cke, busy, lut_addr, lut_data, 8'(i), exp_d);
      end
    end
    @(negedge clk);
    vectors++;
    if ({lut_cke, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL %s_done got cke=%b busy=%b want 0 0", tag, lut_cke, busy);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if ({lut_addr, lut_data, lut_cke, ack_data, ack_stb, busy, err_cnt} !== {8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00}) begin
      miscompares++;
      $display("FAIL reset_vals got addr=%h data=%h cke=%b ack=%h stb=%b busy=%b err=%h",
               lut_addr, lut_data, lut_cke, ack_data, ack_stb, busy, err_cnt);
    end
    reset = 1'b0;
    check_init("init");
  endtask

  task automatic test_valid();
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h0F); send_byte(8'h0C);
    vectors++;
    if (resp() !== {1'b1, 1'b1, 8'h06, 8'h00} || wr() !== 16'h030F) begin
      miscompares++;
      $display("FAIL valid_frame got resp=%h wr=%h want %h %h", resp(), wr(), {1'b1, 1'b1, 8'h06, 8'h00}, 16'h030F);
    end
    @(negedge clk);
    vectors++;
    if ({lut_cke, ack_stb} !== 2'b00) begin
      miscompares++;
      $display("FAIL valid_pulse got cke=%b stb=%b want 0 0", lut_cke, ack_stb);
    end
  endtask

  task automatic test_bad_chk();
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h0F); send_byte(8'h00);
    err_m = sat(err_m);
    vectors++;
    if (resp() !== {1'b0, 1'b1, 8'h15, 8'(err_m)}) begin
      miscompares++;
      $display("FAIL bad_chk got resp=%h want %h", resp(), {1'b0, 1'b1, 8'h15, 8'(err_m)});
    end
  endtask

  task automatic test_bad_row_garbage();
    send_byte(8'hA5); send_byte(8'h09); send_byte(8'h01); send_byte(8'h08);
    err_m = sat(err_m);
    vectors++;
    if (resp() !== {1'b0, 1'b1, 8'h15, 8'(err_m)}) begin
      miscompares++;
      $display("FAIL bad_row got resp=%h want %h", resp(), {1'b0, 1'b1, 8'h15, 8'(err_m)});
    end
    send_byte(8'h11); send_byte(8'h22);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h80); send_byte(8'h82);
    vectors++;
    if (resp() !== {1'b1, 1'b1, 8'h06, 8'(err_m)} || wr() !== 16'h0280) begin
      miscompares++;
      $display("FAIL garbage_then_valid got resp=%h wr=%h want %h %h", resp(), wr(), {1'b1, 1'b1, 8'h06, 8'(err_m)}, 16'h0280);
    end
  endtask

  task automatic test_timeout();
    int a0;
    send_byte(8'hA5); send_byte(8'h03);
    #1 a0 = acks;
    repeat (50) @(negedge clk);
    vectors++;
    if (err_cnt !== 8'(err_m)) begin
      miscompares++;
      $display("FAIL tmo_early got err=%h want %h", err_cnt, 8'(err_m));
    end
    @(negedge clk);
    err_m = sat(err_m);
    #1;
    vectors++;
    if (err_cnt !== 8'(err_m) || acks !== a0) begin
      miscompares++;
      $display("FAIL tmo_expire got err=%h acks=%0d want %h %0d", err_cnt, acks - a0, 8'(err_m), 0);
    end
    send_byte(8'hA5); send_byte(8'h05); send_byte(8'h33); send_byte(8'h36);
    vectors++;
    if (resp() !== {1'b1, 1'b1, 8'h06, 8'(err_m)} || wr() !== 16'h0533) begin
      miscompares++;
      $display("FAIL tmo_recover got resp=%h wr=%h want %h %h", resp(), wr(), {1'b1, 1'b1, 8'h06, 8'(err_m)}, 16'h0533);
    end
    send_byte(8'hA5); send_byte(8'h04);
    repeat (50) @(negedge clk);
    send_byte(8'h55);
    repeat (50) @(negedge clk);
    send_byte(8'h51);
    vectors++;
    if (resp() !== {1'b1, 1'b1, 8'h06, 8'(err_m)} || wr() !== 16'h0455) begin
      miscompares++;
      $display("FAIL tmo_edge got resp=%h wr=%h want %h %h", resp(), wr(), {1'b1, 1'b1, 8'h06, 8'(err_m)}, 16'h0455);
    end
  endtask

  task automatic test_back_to_back();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'hA5); send_byte(8'hA4);
    vectors++;
    if (resp() !== {1'b1, 1'b1, 8'h06, 8'(err_m)} || wr() !== 16'h01A5) begin
      miscompares++;
      $display("FAIL b2b_first got resp=%h wr=%h want %h %h", resp(), wr(), {1'b1, 1'b1, 8'h06, 8'(err_m)}, 16'h01A5);
    end
    send_byte(8'hA5); send_byte(8'h06); send_byte(8'h3C); send_byte(8'h3A);
    vectors++;
    if (resp() !== {1'b1, 1'b1, 8'h06, 8'(err_m)} || wr() !== 16'h063C) begin
      miscompares++;
      $display("FAIL b2b_second got resp=%h wr=%h want %h %h", resp(), wr(), {1'b1, 1'b1, 8'h06, 8'(err_m)}, 16'h063C);
    end
  endtask

  task automatic test_random();
    logic [7:0] row, mask, chk;
    logic ok;
    for (int k = 0; k < 60; k++) begin
      row  = 8'($urandom_range(0, 11));
      mask = 8'($urandom);
      chk  = row ^ mask;
      if ($urandom_range(0, 3) == 0) chk = chk ^ 8'($urandom_range(1, 255));
      if ($urandom_range(0, 2) == 0) send_byte(8'($urandom_range(0, 8'hA4)));
      ok = chk == (row ^ mask) && row < 8'd8;
      if (!ok) err_m = sat(err_m);
      send_byte(8'hA5); gap(); send_byte(row); gap(); send_byte(mask); gap(); send_byte(chk);
      vectors++;
      if (resp() !== {ok, 1'b1, ok ? 8'h06 : 8'h15, 8'(err_m)} || (ok && wr() !== {row, mask})) begin
        miscompares++;
        $display("FAIL random_%0d row=%h mask=%h chk=%h got resp=%h wr=%h want %h %h", k, row, mask, chk,
                 resp(), wr(), {ok, 1'b1, ok ? 8'h06 : 8'h15, 8'(err_m)}, {row, mask});
      end
      gap();
    end
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 260; k++) begin
      send_byte(8'hA5); send_byte(8'h0A); send_byte(8'h00); send_byte(8'h0A);
      err_m = sat(err_m);
    end
    vectors++;
    if (resp() !== {1'b0, 1'b1, 8'h15, 8'hFF} || err_m != 255) begin
      miscompares++;
      $display("FAIL err_saturate got resp=%h want %h", resp(), {1'b0, 1'b1, 8'h15, 8'hFF});
    end
    @(negedge clk);
    #1;
    vectors++;
    if (dbl !== 0) begin
      miscompares++;
      $display("FAIL strobe_single got %0d doubled strobes want 0", dbl);
    end
  endtask

  task automatic test_reset_midframe();
    int w0, a0;
    send_byte(8'hA5); send_byte(8'h03);
    #3 reset = 1'b1;
    #1;
    vectors++;
    if ({lut_addr, lut_data, lut_cke, ack_data, ack_stb, busy, err_cnt} !== {8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00}) begin
      miscompares++;
      $display("FAIL midreset_vals got addr=%h data=%h cke=%b ack=%h stb=%b busy=%b err=%h",
               lut_addr, lut_data, lut_cke, ack_data, ack_stb, busy, err_cnt);
    end
    err_m = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_init("reinit");
    #1 w0 = wrs;
    a0 = acks;
    send_byte(8'h0F); send_byte(8'h0C);
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if (wrs !== w0 || acks !== a0 || err_cnt !== 8'h00) begin
      miscompares++;
      $display("FAIL partial_frame got writes=%0d acks=%0d err=%h want 0 0 00", wrs - w0, acks - a0, err_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_valid();
    test_bad_chk();
    test_bad_row_garbage();
    test_timeout();
    test_back_to_back();
    test_random();
    test_saturate();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
